// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: walks N rail enables up/down, timing each step with an external counter2.
// Optional watchdog per wait state, enabled by defining TIMER_SEQ_WDT_EN.
module timer_seq_ctrl #(
   parameter  int unsigned NUM_STEPS  = 3,
   parameter  int unsigned MAX_COUNT  = 100,
   parameter  int unsigned WDT_CYCLES = 255,
   localparam int unsigned CNT_W      = $clog2(MAX_COUNT + 1)
) (
   input  logic                         iClk,
   input  logic                         iRst,
   input  logic                         iStart,
   input  logic [NUM_STEPS*CNT_W-1:0]   iDlyTable,
   input  logic                         iDone,
   output logic                         oLoad,
   output logic                         oCntEn,
   output logic                         oCntRst_n,
   output logic [CNT_W-1:0]             oSetCnt,
   output logic [NUM_STEPS-1:0]         oStepEn,
   output logic                         oSeqDone,
   output logic                         oBusy,
   output logic                         oFault
);

   localparam int unsigned IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

   if (NUM_STEPS < 1 || NUM_STEPS > 16 || MAX_COUNT < 1 || WDT_CYCLES < 1) begin : g_bad_params
      $error("timer_seq_ctrl: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_UP_LOAD,
      S_UP_WAIT,
      S_ON,
      S_DN_LOAD,
      S_DN_WAIT,
      S_FAULT
   } state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_STEPS-1:0]   step_en_q, step_en_d;
   logic                   load_q, load_d;
   logic                   cnt_en_q, cnt_en_d;
   logic                   cnt_rst_n_q, cnt_rst_n_d;
   logic [CNT_W-1:0]       set_cnt_q, set_cnt_d;
   logic                   seq_done_q, seq_done_d;
   logic                   busy_q, busy_d;
   logic                   wait_s;
   logic [CNT_W-1:0]       dly_a [NUM_STEPS];

`ifdef TIMER_SEQ_WDT_EN
   localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
   logic [WDT_W-1:0]       wdt_q, wdt_d;
   logic                   fault_q, fault_d;
   logic                   wdt_expired;

   assign wdt_expired = (wdt_q == WDT_W'(WDT_CYCLES - 1));
`endif

   // Unpack the flat delay table into per-step entries
   always_comb begin
      for (int i = 0; i < NUM_STEPS; i++) begin
         dly_a[i] = iDlyTable[i*CNT_W +: CNT_W];
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      step_en_d = step_en_q;

      case (state_q)
         S_IDLE: begin
            if (iStart) begin
               state_d = S_UP_LOAD;
               idx_d   = '0;
            end
         end

         S_UP_LOAD, S_UP_WAIT: begin
            // Abort beats a coincident done: the pending step never turns on
            if (!iStart) begin
               if (idx_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d            = S_DN_LOAD;
                  idx_d              = idx_q - IDX_W'(1);
                  step_en_d[idx_d]   = 1'b0;
               end
            end else if (state_q == S_UP_LOAD) begin
               state_d = S_UP_WAIT;
            end else if (iDone) begin
               step_en_d[idx_q] = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = S_ON;
               end else begin
                  state_d = S_UP_LOAD;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end
`ifdef TIMER_SEQ_WDT_EN
            else if (wdt_expired) begin
               state_d   = S_FAULT;
               step_en_d = '0;
            end
`endif
         end

         S_ON: begin
            if (!iStart) begin
               state_d             = S_DN_LOAD;
               idx_d               = LAST_IDX;
               step_en_d[LAST_IDX] = 1'b0;
            end
         end

         S_DN_LOAD: begin
            state_d = S_DN_WAIT;
         end

         S_DN_WAIT: begin
            if (iDone) begin
               if (idx_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d          = S_DN_LOAD;
                  idx_d            = idx_q - IDX_W'(1);
                  step_en_d[idx_d] = 1'b0;
               end
            end
`ifdef TIMER_SEQ_WDT_EN
            else if (wdt_expired) begin
               state_d   = S_FAULT;
               step_en_d = '0;
            end
`endif
         end

         S_FAULT: begin
            step_en_d = '0;
            if (!iStart) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end
         end

         default: begin
            state_d   = S_IDLE;
            idx_d     = '0;
            step_en_d = '0;
         end
      endcase

      // Outputs follow the state being entered so they register alongside it
      wait_s      = (state_d == S_UP_WAIT) || (state_d == S_DN_WAIT);
      load_d      = (state_d == S_UP_LOAD) || (state_d == S_DN_LOAD);
      cnt_en_d    = wait_s;
      cnt_rst_n_d = wait_s;
      set_cnt_d   = load_d ? dly_a[idx_d] : '0;
      seq_done_d  = (state_d == S_ON);
      busy_d      = load_d || wait_s;

`ifdef TIMER_SEQ_WDT_EN
      wdt_d   = wdt_q;
      if ((state_q == S_UP_LOAD) || (state_q == S_DN_LOAD)) begin
         wdt_d = '0;
      end else if ((state_q == S_UP_WAIT) || (state_q == S_DN_WAIT)) begin
         wdt_d = wdt_q + WDT_W'(1);
      end
      fault_d = (state_d == S_FAULT);
`endif
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         step_en_q   <= '0;
         load_q      <= 1'b0;
         cnt_en_q    <= 1'b0;
         cnt_rst_n_q <= 1'b0;
         set_cnt_q   <= '0;
         seq_done_q  <= 1'b0;
         busy_q      <= 1'b0;
`ifdef TIMER_SEQ_WDT_EN
         wdt_q       <= '0;
         fault_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         step_en_q   <= step_en_d;
         load_q      <= load_d;
         cnt_en_q    <= cnt_en_d;
         cnt_rst_n_q <= cnt_rst_n_d;
         set_cnt_q   <= set_cnt_d;
         seq_done_q  <= seq_done_d;
         busy_q      <= busy_d;
`ifdef TIMER_SEQ_WDT_EN
         wdt_q       <= wdt_d;
         fault_q     <= fault_d;
`endif
      end
   end

   assign oLoad     = load_q;
   assign oCntEn    = cnt_en_q;
   assign oCntRst_n = cnt_rst_n_q;
   assign oSetCnt   = set_cnt_q;
   assign oStepEn   = step_en_q;
   assign oSeqDone  = seq_done_q;
   assign oBusy     = busy_q;
`ifdef TIMER_SEQ_WDT_EN
   assign oFault    = fault_q;
`else
   assign oFault    = 1'b0;
`endif

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl with a behavioural counter2 attached; expectations are scheduled
// per clock in a sorted scoreboard and compared on the falling edge.
module tb_timer_seq_ctrl;

   localparam int unsigned NUM_STEPS  = 3;
   localparam int unsigned MAX_COUNT  = 100;
   localparam int unsigned WDT_CYCLES = 16;
   localparam int unsigned CNT_W      = 7;

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         start;
   logic [NUM_STEPS*CNT_W-1:0]   dly_table;
   logic                         done;
   logic                         load;
   logic                         cnt_en;
   logic                         cnt_rst_n;
   logic [CNT_W-1:0]             set_cnt;
   logic [NUM_STEPS-1:0]         step_en;
   logic                         seq_done;
   logic                         busy;
   logic                         fault;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   timer_seq_ctrl #(
      .NUM_STEPS (NUM_STEPS),
      .MAX_COUNT (MAX_COUNT),
      .WDT_CYCLES(WDT_CYCLES)
   ) dut (
      .iClk     (clk),
      .iRst     (rst),
      .iStart   (start),
      .iDlyTable(dly_table),
      .iDone    (done),
      .oLoad    (load),
      .oCntEn   (cnt_en),
      .oCntRst_n(cnt_rst_n),
      .oSetCnt  (set_cnt),
      .oStepEn  (step_en),
      .oSeqDone (seq_done),
      .oBusy    (busy),
      .oFault   (fault)
   );

   // counter2 model: load wins over clear, counts down to zero while enabled
   logic [CNT_W-1:0] cnt_q;
   logic             hold_done_low = 1'b0;
   always @(posedge clk) begin
      if (load)                        cnt_q <= set_cnt;
      else if (!cnt_rst_n)             cnt_q <= '0;
      else if (cnt_en && cnt_q != '0)  cnt_q <= cnt_q - CNT_W'(1);
   end
   assign done = (cnt_q == '0) && !hold_done_low;

   typedef struct {
      int          cyc;
      int          sel;
      logic [15:0] exp;
      string       tag;
   } exp_t;

   exp_t sb[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
      end
   endtask

   // sel 0: {step_en, seq_done, busy, fault}; 1: {load, cnt_en, cnt_rst_n, set_cnt}; 2: {load, cnt_en, cnt_rst_n}
   function automatic logic [15:0] observe(input int sel);
      case (sel)
         0:       return 16'({step_en, seq_done, busy, fault});
         1:       return 16'({load, cnt_en, cnt_rst_n, set_cnt});
         default: return 16'({load, cnt_en, cnt_rst_n});
      endcase
   endfunction

   function automatic logic [15:0] st(input logic [2:0] se, input logic sd, input logic bz, input logic ft);
      return 16'({se, sd, bz, ft});
   endfunction

   function automatic logic [15:0] ld(input logic [CNT_W-1:0] v);
      return 16'({1'b1, 1'b0, 1'b0, v});
   endfunction

   task automatic push(input int c, input int sel, input logic [15:0] v, input string tag);
      exp_t e;
      int   pos;
      e.cyc = c; e.sel = sel; e.exp = v; e.tag = tag;
      pos = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc > c) begin
            pos = i;
            break;
         end
      end
      sb.insert(pos, e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         check_eq(e.tag, 32'(observe(e.sel)), 32'(e.exp));
      end
   end

   // Power-up from iStart=1 driven after edge t0: rails at +8, +10, +22 for delays {10,0,5}
   task automatic push_up(input int t0, input int upto, input string tag);
      logic [2:0] se;
      for (int c = t0 + 1; c <= upto; c++) begin
         se = (c >= t0 + 22) ? 3'b111 : (c >= t0 + 10) ? 3'b011 : (c >= t0 + 8) ? 3'b001 : 3'b000;
         push(c, 0, st(se, c >= t0 + 22, c < t0 + 22, 1'b0), tag);
      end
      if (t0 + 1 <= upto)  push(t0 + 1, 1, ld(7'd5), {tag, "_ld0"});
      if (t0 + 2 <= upto)  push(t0 + 2, 2, 16'(3'b011), {tag, "_wait"});
      if (t0 + 8 <= upto)  push(t0 + 8, 1, ld(7'd0), {tag, "_ld1"});
      if (t0 + 10 <= upto) push(t0 + 10, 1, ld(7'd10), {tag, "_ld2"});
      if (t0 + 22 <= upto) push(t0 + 22, 2, 16'(3'b000), {tag, "_on_idle_cnt"});
   endtask

   // Power-down from ON with iStart=0 driven after edge t
   task automatic push_dn(input int t, input int upto, input string tag);
      logic [2:0] se;
      for (int c = t + 1; c <= upto; c++) begin
         se = (c >= t + 15) ? 3'b000 : (c >= t + 13) ? 3'b001 : 3'b011;
         push(c, 0, st(se, 1'b0, c < t + 22, 1'b0), tag);
      end
      if (t + 1 <= upto)  push(t + 1, 1, ld(7'd10), {tag, "_ld2"});
      if (t + 13 <= upto) push(t + 13, 1, ld(7'd0), {tag, "_ld1"});
      if (t + 15 <= upto) push(t + 15, 1, ld(7'd5), {tag, "_ld0"});
      if (t + 22 <= upto) push(t + 22, 2, 16'(3'b000), {tag, "_idle_cnt"});
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin : timeout
      #100000;
      $display("FAIL timeout: simulation did not finish, cyc %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int t;
      rst       = 1'b1;
      start     = 1'b0;
      dly_table = {7'd10, 7'd0, 7'd5};

      for (int c = 1; c <= 4; c++) begin
         push(c, 0, 16'd0, "reset_st");
         push(c, 1, 16'd0, "reset_cnt");
      end
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(5);

      // Full power-up then power-down
      t = cyc; start = 1'b1; push_up(t, t + 24, "up");
      wait_cyc(t + 24);
      t = cyc; start = 1'b0; push_dn(t, t + 24, "dn");
      wait_cyc(t + 24);

      // iStart re-asserted during DN_WAIT: down completes, then full up restarts
      t = cyc; start = 1'b1; push_up(t, t + 23, "up2");
      wait_cyc(t + 23);
      t = cyc; start = 1'b0; push_dn(t, t + 22, "dn_tog");
      wait_cyc(t + 3);
      start = 1'b1; push_up(t + 22, t + 46, "reup");
      wait_cyc(t + 46);
      t = cyc; start = 1'b0; push_dn(t, t + 23, "dn3");
      wait_cyc(t + 23);

      // Abort while step 1 is loading (step 0 on)
      t = cyc; start = 1'b1; push_up(t, t + 8, "ab1_up");
      wait_cyc(t + 8);
      start = 1'b0;
      for (int c = t + 9; c <= t + 17; c++) push(c, 0, st(3'b000, 1'b0, c < t + 16, 1'b0), "ab1_dn");
      push(t + 9, 1, ld(7'd5), "ab1_ld0");
      wait_cyc(t + 18);

      // Abort coinciding with done in step 1's wait: step 1 must stay off
      t = cyc; start = 1'b1; push_up(t, t + 9, "abw_up");
      wait_cyc(t + 9);
      start = 1'b0;
      for (int c = t + 10; c <= t + 18; c++) push(c, 0, st(3'b000, 1'b0, c < t + 17, 1'b0), "abw_dn");
      push(t + 10, 1, ld(7'd5), "abw_ld0");
      wait_cyc(t + 19);

      // Abort during step 0: straight back to idle
      t = cyc; start = 1'b1; push_up(t, t + 3, "ab0_up");
      wait_cyc(t + 3);
      start = 1'b0;
      for (int c = t + 4; c <= t + 6; c++) push(c, 0, 16'd0, "ab0_idle");
      wait_cyc(t + 7);

      // Reset held 3 clocks in step 2's wait
      t = cyc; start = 1'b1; push_up(t, t + 13, "rst_up");
      wait_cyc(t + 13);
      rst = 1'b1; start = 1'b0;
      for (int c = t + 14; c <= t + 18; c++) begin
         push(c, 0, 16'd0, "midrst_st");
         push(c, 1, 16'd0, "midrst_cnt");
      end
      wait_cyc(t + 16);
      rst = 1'b0;
      wait_cyc(t + 19);

`ifdef TIMER_SEQ_WDT_EN
      // Watchdog: done never arrives, fault after WDT_CYCLES wait clocks
      begin
         int f;
         t = cyc; hold_done_low = 1'b1; start = 1'b1;
         f = t + 2 + int'(WDT_CYCLES);
         push(f - 1, 0, st(3'b000, 1'b0, 1'b1, 1'b0), "wdt_pre");
         push(f, 0, st(3'b000, 1'b0, 1'b0, 1'b1), "wdt_fault");
         push(f + 1, 0, st(3'b000, 1'b0, 1'b0, 1'b1), "wdt_hold");
         wait_cyc(f + 1);
         start = 1'b0;
         push(f + 2, 0, 16'd0, "wdt_clear");
         wait_cyc(f + 3);
         hold_done_low = 1'b0;
      end
`endif

      wait_cyc(cyc + 2);
      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
